// File: rtl/enabled_valid_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : enabled_valid_pipe_pkg
// Brief    : Shared defaults and occupancy width helper for enabled_valid_pipe.
// Revision : 1.0 - initial release
// ============================================================================
package enabled_valid_pipe_pkg;

   localparam int c_DEF_WIDTH = 8;
   localparam int c_DEF_DEPTH = 2;
   localparam int c_DEF_CNT_W = 8;

   // Occupancy must represent 0..depth inclusive.
   function automatic int occ_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/enabled_valid_stage.sv
`default_nettype none
// ============================================================================
// Module   : enabled_valid_stage
// Brief    : One clock-enabled valid/data register stage of the elastic pipe.
// Revision : 1.0 - initial release
// ============================================================================
module enabled_valid_stage
   import enabled_valid_pipe_pkg::*;
#(
   parameter int WIDTH = c_DEF_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             up_valid_i,
   input  logic [WIDTH-1:0] up_data_i,
   input  logic             dn_ready_i,
   output logic             valid_o,
   output logic [WIDTH-1:0] data_o
);

   typedef struct packed {
      logic             valid;
      logic [WIDTH-1:0] data;
   } stage_t;

   stage_t stage_q;
   stage_t stage_d;
   logic   w_move;
   logic   w_load;

   assign w_move = en & stage_q.valid & dn_ready_i;
   assign w_load = en & (~stage_q.valid | w_move);

   always_comb begin
      stage_d = stage_q;
      if (w_load) begin
         stage_d.valid = up_valid_i;
         // Data register only captures real items.
         if (up_valid_i) begin
            stage_d.data = up_data_i;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stage_q <= '0;
      end else begin
         stage_q <= stage_d;
      end
   end

   assign valid_o = stage_q.valid;
   assign data_o  = stage_q.data;

endmodule
`default_nettype wire

// File: rtl/enabled_valid_pipe.sv
`default_nettype none
// ============================================================================
// Module   : enabled_valid_pipe
// Brief    : DEPTH-stage clock-enabled valid/ready pipe with occupancy output.
//            Define ENABLED_PIPE_STALL_CNT_EN to add the saturating stall_cnt.
// Revision : 1.0 - initial release
// ============================================================================
module enabled_valid_pipe
   import enabled_valid_pipe_pkg::*;
#(
   parameter int WIDTH = c_DEF_WIDTH,
   parameter int DEPTH = c_DEF_DEPTH,
   parameter int CNT_W = c_DEF_CNT_W
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            en,
   input  logic                            in_valid,
   output logic                            in_ready,
   input  logic [WIDTH-1:0]                in_data,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic [WIDTH-1:0]                out_data,
   output logic [occ_width(DEPTH)-1:0]     occupancy
`ifdef ENABLED_PIPE_STALL_CNT_EN
   ,
   output logic [CNT_W-1:0]                stall_cnt
`endif
);

   localparam int c_OCC_W = occ_width(DEPTH);

   if (WIDTH < 1 || DEPTH < 1 || CNT_W < 1) begin : g_bad_params
      $error("enabled_valid_pipe: WIDTH, DEPTH and CNT_W must all be >= 1");
   end

   logic [DEPTH-1:0] w_v;
   logic [DEPTH-1:0] w_dn;
   logic [WIDTH-1:0] w_d [DEPTH];
   logic             w_acc;
   logic             w_push;
   logic             w_pop;
   logic [c_OCC_W-1:0] occ_q;
   logic [c_OCC_W-1:0] occ_d;

   // Ready ripples from the consumer back to the producer; it is rebuilt here
   // from the registered valids so no combinational path loops between stages.
   always_comb begin
      w_dn  = '0;
      w_acc = out_ready;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         w_dn[i] = w_acc;
         w_acc   = en & (~w_v[i] | w_acc);
      end
   end

   assign in_ready = w_acc;

   for (genvar i = 0; i < DEPTH; i++) begin : g_stage
      logic             w_up_v;
      logic [WIDTH-1:0] w_up_d;

      if (i == 0) begin : g_head
         assign w_up_v = in_valid;
         assign w_up_d = in_data;
      end else begin : g_body
         assign w_up_v = w_v[i-1];
         assign w_up_d = w_d[i-1];
      end

      enabled_valid_stage #(
         .WIDTH (WIDTH)
      ) u_stage (
         .clk        (clk),
         .reset      (reset),
         .en         (en),
         .up_valid_i (w_up_v),
         .up_data_i  (w_up_d),
         .dn_ready_i (w_dn[i]),
         .valid_o    (w_v[i]),
         .data_o     (w_d[i])
      );
   end

   assign out_valid = en & w_v[DEPTH-1];
   assign out_data  = w_d[DEPTH-1];

   assign w_push = in_valid & in_ready;
   assign w_pop  = out_valid & out_ready;

   always_comb begin
      occ_d = occ_q;
      if (w_push && !w_pop) begin
         occ_d = occ_q + 1'b1;
      end else if (!w_push && w_pop) begin
         occ_d = occ_q - 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         occ_q <= '0;
      end else begin
         occ_q <= occ_d;
      end
   end

   assign occupancy = occ_q;

`ifdef ENABLED_PIPE_STALL_CNT_EN
   logic [CNT_W-1:0] stall_q;
   logic [CNT_W-1:0] stall_d;

   always_comb begin
      stall_d = stall_q;
      if (en && w_v[DEPTH-1] && !out_ready && !(&stall_q)) begin
         stall_d = stall_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_q <= '0;
      end else begin
         stall_q <= stall_d;
      end
   end

   assign stall_cnt = stall_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_enabled_valid_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_enabled_valid_pipe
// Brief    : Directed self-checking bench for enabled_valid_pipe (DEPTH 2 and 3).
// Revision : 1.0 - initial release
// ============================================================================
module tb_enabled_valid_pipe;

   logic       clk = 1'b0;
   logic       reset;
   logic       en;
   logic       in_valid;
   logic [7:0] in_data;
   logic       out_ready;

   logic       rdy2, vld2, rdy3, vld3;
   logic [7:0] dat2, dat3;
   logic [1:0] occ2, occ3;
`ifdef ENABLED_PIPE_STALL_CNT_EN
   logic [1:0] stall2;
   logic [7:0] stall3;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   enabled_valid_pipe #(.WIDTH(8), .DEPTH(2), .CNT_W(2)) u_dut2 (
      .clk       (clk),
      .reset     (reset),
      .en        (en),
      .in_valid  (in_valid),
      .in_ready  (rdy2),
      .in_data   (in_data),
      .out_valid (vld2),
      .out_ready (out_ready),
      .out_data  (dat2),
      .occupancy (occ2)
`ifdef ENABLED_PIPE_STALL_CNT_EN
      ,
      .stall_cnt (stall2)
`endif
   );

   enabled_valid_pipe #(.WIDTH(8), .DEPTH(3), .CNT_W(8)) u_dut3 (
      .clk       (clk),
      .reset     (reset),
      .en        (en),
      .in_valid  (in_valid),
      .in_ready  (rdy3),
      .in_data   (in_data),
      .out_valid (vld3),
      .out_ready (out_ready),
      .out_data  (dat3),
      .occupancy (occ3)
`ifdef ENABLED_PIPE_STALL_CNT_EN
      ,
      .stall_cnt (stall3)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int  n_out;
      int  first;
      int  last;
      logic acc;

      reset = 1'b1; en = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
      #12 reset = 1'b0;
      #1;
      chk("rst_out_valid", vld2, 1'b0);
      chk("rst_occ", occ2, 2'd0);
      chk("rst_out_data", dat2, 8'h00);
      chk("rst_in_ready", rdy2, 1'b1);
      chk("rst_occ3", occ3, 2'd0);

      // Fill DEPTH=2 then reset between edges.
      in_valid = 1'b1; in_data = 8'hA1; tick();
      in_data = 8'hA2; tick();
      in_valid = 1'b0; #1;
      chk("fill_occ", occ2, 2'd2);
      chk("fill_out_valid", vld2, 1'b1);
      chk("fill_out_data", dat2, 8'hA1);
      #1 reset = 1'b1;
      #1;
      chk("async_rst_out_valid", vld2, 1'b0);
      chk("async_rst_occ", occ2, 2'd0);
      #1 reset = 1'b0;
      #1;
      chk("post_rst_out_data", dat2, 8'h00);
      chk("post_rst_occ", occ2, 2'd0);

      // Back-to-back stream 0x01..0x10 through DEPTH=3.
      out_ready = 1'b1; in_valid = 1'b1; in_data = 8'h01;
      n_out = 0; first = -1; last = -1;
      for (int cyc = 0; cyc < 40 && n_out < 16; cyc++) begin
         if (in_valid) chk("thr_in_ready", rdy3, 1'b1);
         acc = in_valid & rdy3;
         tick();
         if (acc) begin
            if (in_data == 8'h10) in_valid = 1'b0;
            else in_data = in_data + 8'h01;
         end
         #1;
         if (vld3) begin
            if (first < 0) first = cyc;
            last = cyc;
            chk("thr_data", dat3, n_out + 1);
            n_out++;
         end
      end
      chk("thr_first_latency", first, 2);
      chk("thr_last_cycle", last, 17);
      chk("thr_count", n_out, 16);
      tick(); #1;
      chk("thr_drained_occ", occ3, 2'd0);
      chk("thr_drained_valid", vld3, 1'b0);

      // Back-pressure on DEPTH=2, then simultaneous push and pop when full.
      out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h11; #1;
      chk("bp_rdy_empty", rdy2, 1'b1);
      tick();
      in_data = 8'h22; #1;
      chk("bp_rdy_half", rdy2, 1'b1);
      tick();
      in_data = 8'h33; #1;
      chk("bp_rdy_full", rdy2, 1'b0);
      chk("bp_occ_full", occ2, 2'd2);
      chk("bp_head", dat2, 8'h11);
      tick(); #1;
      chk("bp_hold_occ", occ2, 2'd2);
      chk("bp_hold_head", dat2, 8'h11);
      out_ready = 1'b1; #1;
      chk("pushpop_rdy", rdy2, 1'b1);
      chk("pushpop_valid", vld2, 1'b1);
      tick();
      in_valid = 1'b0; #1;
      chk("pushpop_occ", occ2, 2'd2);
      chk("bp_second", dat2, 8'h22);
      tick(); #1;
      chk("bp_third", dat2, 8'h33);
      chk("bp_occ_one", occ2, 2'd1);
      tick(); #1;
      chk("bp_empty_valid", vld2, 1'b0);
      chk("bp_empty_occ", occ2, 2'd0);

      // Enable freeze with a single item resident.
      reset = 1'b1; #1 reset = 1'b0; #1;
      out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h5A; tick();
      in_valid = 1'b0; tick(); #1;
      chk("frz_pre_valid", vld2, 1'b1);
      chk("frz_pre_data", dat2, 8'h5A);
      chk("frz_pre_occ", occ2, 2'd1);
      en = 1'b0; out_ready = 1'b1; in_valid = 1'b1; in_data = 8'h77; #1;
      chk("frz_out_valid", vld2, 1'b0);
      chk("frz_in_ready", rdy2, 1'b0);
      for (int k = 0; k < 4; k++) begin
         tick(); #1;
         chk("frz_occ_hold", occ2, 2'd1);
         chk("frz_valid_low", vld2, 1'b0);
      end
      in_valid = 1'b0; en = 1'b1; #1;
      chk("frz_restore_valid", vld2, 1'b1);
      chk("frz_restore_data", dat2, 8'h5A);
      tick(); #1;
      chk("frz_done_valid", vld2, 1'b0);
      chk("frz_done_occ", occ2, 2'd0);
      tick(); #1;
      chk("frz_once", vld2, 1'b0);

`ifdef ENABLED_PIPE_STALL_CNT_EN
      reset = 1'b1; #1 reset = 1'b0; #1;
      chk("stall_rst", stall2, 2'd0);
      out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h99; tick();
      in_valid = 1'b0; tick(); #1;
      chk("stall_arrive", stall2, 2'd0);
      tick(); tick(); #1;
      chk("stall_two", stall2, 2'd2);
      tick(); tick(); tick(); tick(); #1;
      chk("stall_sat", stall2, 2'd3);
      reset = 1'b1; #1;
      chk("stall_clear", stall2, 2'd0);
      reset = 1'b0; #1;
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
